// File: rtl/snn_cfg_sequencer.sv
// rtl/snn_cfg_sequencer.sv - host command sequencer owning the snn_layer configuration port
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake
//   cmd_op                0=weight write, 1=delay write, 2=fill all, 3=reserved
//   cmd_addr              synapse index (neuron*NUM_INPUTS + input)
//   cmd_wdata, cmd_delay  weight / delay payload
//   spikes_in/spikes_out  raw and gated pre-synaptic spikes
//   cfg_*                 registered layer configuration write port
//   busy, done, cmd_err   status: active, completion pulse, rejection pulse
//   drop_count            saturating count of spikes discarded while gated
module snn_cfg_sequencer #(
    parameter int NUM_INPUTS    = 8,
    parameter int NUM_NEURONS   = 1,
    parameter int WW            = 16,
    parameter int SETTLE_CYCLES = 5,
    parameter int ADDR_W        = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
    parameter int DROP_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [WW-1:0]         cmd_wdata,
    input  logic [7:0]            cmd_delay,
    input  logic [NUM_INPUTS-1:0] spikes_in,
    output logic [NUM_INPUTS-1:0] spikes_out,
    output logic                  cfg_we,
    output logic                  cfg_sel_delay,
    output logic [ADDR_W-1:0]     cfg_addr,
    output logic [WW-1:0]         cfg_wdata,
    output logic [7:0]            cfg_delay,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int N     = NUM_INPUTS * NUM_NEURONS;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   N_EXT     = (ADDR_W + 1)'(N);

    typedef enum logic [2:0] {IDLE, WRITE, FILL_W, FILL_D, SETTLE} state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             gate_open;
    logic             addr_oob;
    logic [DROP_W:0]  pop;
    logic [DROP_W:0]  drop_sum;

    assign gate_open  = (state == IDLE);
    assign cmd_ready  = (state == IDLE) && rst_n;
    assign busy       = (state != IDLE);
    assign spikes_out = gate_open ? spikes_in : '0;
    assign addr_oob   = ({1'b0, cmd_addr} >= N_EXT);

    // One extra bit on the sum catches overflow for saturation.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pop = pop + (DROP_W + 1)'(spikes_in[i]);
        end
        drop_sum = {1'b0, drop_count} + pop;
    end

    // cfg_* are loaded with the values for the state being entered, so the
    // write strobe appears in the first cycle of WRITE/FILL_*.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            cfg_we        <= 1'b0;
            cfg_sel_delay <= 1'b0;
            cfg_addr      <= '0;
            cfg_wdata     <= '0;
            cfg_delay     <= '0;
            done          <= 1'b0;
            cmd_err       <= 1'b0;
            drop_count    <= '0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            if (!gate_open) begin
                drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == 2'd3 || (cmd_op != 2'd2 && addr_oob)) begin
                            cmd_err <= 1'b1;
                        end else begin
                            cfg_we    <= 1'b1;
                            cfg_wdata <= cmd_wdata;
                            cfg_delay <= cmd_delay;
                            if (cmd_op == 2'd2) begin
                                state         <= FILL_W;
                                cfg_sel_delay <= 1'b0;
                                cfg_addr      <= '0;
                            end else begin
                                state         <= WRITE;
                                cfg_sel_delay <= cmd_op[0];
                                cfg_addr      <= cmd_addr;
                            end
                        end
                    end
                end
                WRITE: begin
                    cfg_we <= 1'b0;
                    if (SETTLE_CYCLES == 0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES);
                    end
                end
                FILL_W: begin
                    if (cfg_addr == LAST_ADDR) begin
                        state         <= FILL_D;
                        cfg_sel_delay <= 1'b1;
                        cfg_addr      <= '0;
                    end else begin
                        cfg_addr <= cfg_addr + 1'b1;
                    end
                end
                FILL_D: begin
                    if (cfg_addr == LAST_ADDR) begin
                        cfg_we <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= CNT_W'(SETTLE_CYCLES);
                        end
                    end else begin
                        cfg_addr <= cfg_addr + 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
